// File: rtl/ka_gf2_mul_seq.sv
// Multi-cycle Karatsuba carry-less multiplier over GF(2).
// One shared N/2 clmul, optional two-fold reduction mod x^N+POLY.
module ka_gf2_mul_seq #(
  parameter int         N    = 64,
  parameter logic [N-1:0] POLY = 'h1B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           reduce,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy
);

  localparam int H = N / 2;
  localparam int P = N - 1;
  localparam int W = 2 * N - 1;

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    MUL_HI,
    MUL_MID,
    COMBINE,
    FOLD1,
    FOLD2,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0] a_q, b_q;
  logic         reduce_q;
  logic [P-1:0] p_lo, p_hi, p_mid;
  logic [W-1:0] r_q;

  logic [H-1:0] mx, mz;
  logic [P-1:0] pm;
  logic [P-1:0] m;

  function automatic logic [P-1:0] clmul_h(
    input logic [H-1:0] x,
    input logic [H-1:0] z
  );
    logic [P-1:0] acc;
    acc = '0;
    for (int i = 0; i < H; i++)
      if (x[i]) acc = acc ^ (P'(z) << i);
    return acc;
  endfunction

  // x^N == POLY, so the upper half folds back as hi*POLY
  function automatic logic [W-1:0] fold(
    input logic [W-1:0] v
  );
    logic [W-1:0] acc;
    acc = W'(v[N-1:0]);
    for (int i = 0; i < N; i++)
      if (POLY[i]) acc = acc ^ (W'(v[W-1:N]) << i);
    return acc;
  endfunction

  always_comb begin
    mx = '0;
    mz = '0;
    unique case (state_q)
      MUL_LO: begin
        mx = a_q[H-1:0];
        mz = b_q[H-1:0];
      end
      MUL_HI: begin
        mx = a_q[N-1:H];
        mz = b_q[N-1:H];
      end
      MUL_MID: begin
        mx = a_q[H-1:0] ^ a_q[N-1:H];
        mz = b_q[H-1:0] ^ b_q[N-1:H];
      end
      default: ;
    endcase
  end

  assign pm = clmul_h(mx, mz);
  assign m  = p_lo ^ p_hi ^ p_mid;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL_LO;
      end
      MUL_LO:  state_d = MUL_HI;
      MUL_HI:  state_d = MUL_MID;
      MUL_MID: state_d = COMBINE;
      COMBINE: state_d = reduce_q ? FOLD1 : DONE;
      FOLD1:   state_d = FOLD2;
      FOLD2:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign y    = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      reduce_q <= 1'b0;
      p_lo     <= '0;
      p_hi     <= '0;
      p_mid    <= '0;
      r_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            reduce_q <= reduce;
          end
        end
        MUL_LO:  p_lo  <= pm;
        MUL_HI:  p_hi  <= pm;
        MUL_MID: p_mid <= pm;
        COMBINE: begin
          r_q <= W'(p_lo) ^ (W'(m) << H) ^ (W'(p_hi) << N);
        end
        FOLD1:   r_q <= fold(r_q);
        FOLD2:   r_q <= fold(r_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ka_gf2_mul_seq.sv
// Directed and random checks for ka_gf2_mul_seq
// at N=8 and N=64.
module tb_ka_gf2_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        rst8, iv8, ir8, red8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [14:0] y8;

  logic         rst64, iv64, ir64, red64, ov64, or64, busy64;
  logic [63:0]  a64, b64;
  logic [126:0] y64;

  ka_gf2_mul_seq #(.N(8), .POLY(8'h1B)) dut8 (
    .clk(clk), .rst(rst8),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .reduce(red8),
    .out_valid(ov8), .out_ready(or8),
    .y(y8), .busy(busy8)
  );

  ka_gf2_mul_seq #(.N(64), .POLY(64'h1B)) dut64 (
    .clk(clk), .rst(rst64),
    .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .reduce(red64),
    .out_valid(ov64), .out_ready(or64),
    .y(y64), .busy(busy64)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(
    input logic [63:0] x,
    input logic [63:0] z,
    input bit          red
  );
    logic [127:0] v;
    logic [127:0] f;
    v = '0;
    for (int i = 0; i < 64; i++)
      if (x[i]) v = v ^ ({64'b0, z} << i);
    if (red) begin
      f = {63'b0, 1'b1, 64'h1B};
      for (int k = 126; k >= 64; k--)
        if (v[k]) v = v ^ (f << (k - 64));
    end
    return v;
  endfunction

  task automatic op8(
    input  logic [7:0] a, input logic [7:0] b,
    input  bit red, output int lat
  );
    int n;
    @(negedge clk);
    a8 = a; b8 = b; red8 = red; iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk);
    #1;
    iv8 = 1'b0; a8 = ~a; b8 = ~b; red8 = ~red;
    lat = 0;
    while (!ov8 && lat < 50) begin
      @(posedge clk); lat++; #1;
    end
  endtask

  task automatic take8();
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;
    check("t8_ov", 128'(ov8), 128'd0);
    check("t8_busy", 128'(busy8), 128'd0);
  endtask

  task automatic op64(
    input  logic [63:0] a, input logic [63:0] b,
    input  bit red, output int lat
  );
    int n;
    @(negedge clk);
    a64 = a; b64 = b; red64 = red; iv64 = 1'b1;
    n = 0;
    while (!ir64 && n < 50) begin
      @(negedge clk); n++;
    end
    @(posedge clk);
    #1;
    iv64 = 1'b0; a64 = ~a; red64 = ~red;
    lat = 0;
    while (!ov64 && lat < 50) begin
      @(posedge clk); lat++; #1;
    end
  endtask

  task automatic take64();
    or64 = 1'b1;
    @(posedge clk);
    #1;
    or64 = 1'b0;
  endtask

  initial begin
    int lat;
    logic [14:0] yh;
    logic [63:0] ra, rb;
    bit rr;

    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0;
    a8 = '0; b8 = '0; red8 = 1'b0;
    rst64 = 1'b1; iv64 = 1'b0; or64 = 1'b0;
    a64 = '0; b64 = '0; red64 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ir", 128'(ir8), 128'd1);
    check("rst_ov", 128'(ov8), 128'd0);
    check("rst_busy", 128'(busy8), 128'd0);
    check("rst_y", 128'(y8), 128'd0);
    @(negedge clk);
    rst8 = 1'b0; rst64 = 1'b0;

    op8(8'h57, 8'h83, 1'b0, lat);
    check("lat_plain", 128'(lat), 128'd4);
    check("y_5783", 128'(y8), 128'h2B79);
    take8();

    op8(8'h57, 8'h83, 1'b1, lat);
    check("lat_red", 128'(lat), 128'd6);
    check("y_5783_red", 128'(y8), 128'h00C1);
    check("red_hi0", 128'(y8[14:8]), 128'd0);
    take8();

    op8(8'hFF, 8'hFF, 1'b0, lat);
    check("y_ffff", 128'(y8), 128'h5555);
    take8();

    op8(8'h00, 8'hA5, 1'b0, lat);
    check("y_zero", 128'(y8), 128'd0);
    take8();
    op8(8'h00, 8'hA5, 1'b1, lat);
    check("y_zero_red", 128'(y8), 128'd0);
    take8();
    op8(8'h01, 8'hA5, 1'b1, lat);
    check("y_one_red", 128'(y8), 128'h00A5);
    take8();

    op8(8'h57, 8'h83, 1'b0, lat);
    yh = y8;
    check("bp_y0", 128'(yh), 128'h2B79);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        a8 = 8'h12; b8 = 8'h34; red8 = 1'b1; iv8 = 1'b1;
      end else begin
        iv8 = 1'b0;
      end
      check("bp_y", 128'(y8), 128'(yh));
      check("bp_ov", 128'(ov8), 128'd1);
      check("bp_ir", 128'(ir8), 128'd0);
    end
    iv8 = 1'b0;
    take8();
    check("bp_ir_idle", 128'(ir8), 128'd1);
    op8(8'h01, 8'hA5, 1'b0, lat);
    check("bp_next", 128'(y8), 128'h00A5);
    check("bp_next_lat", 128'(lat), 128'd4);
    take8();

    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; red8 = 1'b1; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    @(posedge clk);
    #1 rst8 = 1'b1;
    #1;
    check("ar_ov", 128'(ov8), 128'd0);
    check("ar_ir", 128'(ir8), 128'd1);
    check("ar_busy", 128'(busy8), 128'd0);
    @(negedge clk);
    rst8 = 1'b0;
    check("ar_ov2", 128'(ov8), 128'd0);
    op8(8'h57, 8'h83, 1'b0, lat);
    check("ar_lat", 128'(lat), 128'd4);
    check("ar_y", 128'(y8), 128'h2B79);
    take8();

    op64(64'h8000_0000_0000_0000, 64'h2, 1'b1, lat);
    check("w_lat_red", 128'(lat), 128'd6);
    check("w_red", 128'(y64), 128'h1B);
    take64();
    op64(64'h8000_0000_0000_0000, 64'h2, 1'b0, lat);
    check("w_lat", 128'(lat), 128'd4);
    check("w_plain", 128'(y64), 128'h1 << 64);
    take64();

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rr = 1'($urandom_range(1, 0));
      op64(ra, rb, rr, lat);
      check("rnd", 128'(y64), ref_mul(ra, rb, rr));
      take64();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
